// File: rtl/alu_unit_pkg.sv
// Shared definitions for the ALU: opcode mnemonics and the datapath width.
package alu_unit_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [3:0] {
        LSH   = 4'b0000,
        RSH   = 4'b0001,
        AND   = 4'b0010,
        OR    = 4'b0011,
        XOR   = 4'b0100,
        SUB   = 4'b0101,
        PASSA = 4'b0110,
        PASSB = 4'b0111,
        GEQ   = 4'b1000,
        EQ    = 4'b1001,
        NEG   = 4'b1010,
        ADD   = 4'b1011,
        LT    = 4'b1100,
        NEQ   = 4'b1101,
        RSV0  = 4'b1110,
        RSV1  = 4'b1111
    } op_mne;

endpackage

// File: rtl/alu_flag_reg.sv
// Status flag register: synchronous active-low clear, load enable, hold otherwise.
module alu_flag_reg
    import alu_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] d,
    output logic [2:0] q
);

    logic [2:0] flag_reg;

    // Clear wins over load so a reset edge never captures stale flags.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_flag
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    flag_reg[gi] <= 1'b0;
                end else if (load) begin
                    flag_reg[gi] <= d[gi];
                end
            end
        end
    endgenerate

    assign q = flag_reg;

endmodule

// File: rtl/alu_unit.sv
// 8-bit ALU with a combinational result path and a clocked Zero/Even/Carry status register.
module alu_unit
    import alu_unit_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic [3:0]       OP,
    input  logic             FlagEn,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Even,
    output logic             FlagZero,
    output logic             FlagEven,
    output logic             FlagCarry
);

    op_mne            op;
    logic [WIDTH:0]   sum_wide;
    logic [WIDTH-1:0] result_next;
    logic             carry_next;
    logic [2:0]       flag_q;

    assign op       = op_mne'(OP);
    assign sum_wide = {1'b0, InputA} + {1'b0, InputB};

    always_comb begin
        result_next = '0;
        carry_next  = 1'b0;
        case (op)
            LSH: begin
                result_next = {InputA[WIDTH-2:0], 1'b0};
                carry_next  = InputA[WIDTH-1];
            end
            RSH: begin
                result_next = {1'b0, InputA[WIDTH-1:1]};
                carry_next  = InputA[0];
            end
            AND:   result_next = InputA & InputB;
            OR:    result_next = InputA | InputB;
            XOR:   result_next = InputA ^ InputB;
            SUB: begin
                result_next = InputA - InputB;
                carry_next  = (InputA < InputB);
            end
            PASSA: result_next = InputA;
            PASSB: result_next = InputB;
            GEQ:   result_next = {{(WIDTH-1){1'b0}}, (InputA >= InputB)};
            EQ:    result_next = {{(WIDTH-1){1'b0}}, (InputA == InputB)};
            NEG:   result_next = ~InputA + {{(WIDTH-1){1'b0}}, 1'b1};
            ADD: begin
                result_next = sum_wide[WIDTH-1:0];
                carry_next  = sum_wide[WIDTH];
            end
            LT:    result_next = {{(WIDTH-1){1'b0}}, (InputA < InputB)};
            NEQ:   result_next = {{(WIDTH-1){1'b0}}, (InputA != InputB)};
            default: begin
                result_next = '0;
                carry_next  = 1'b0;
            end
        endcase
    end

    assign Out  = result_next;
    assign Zero = (result_next == '0);
    assign Even = ~result_next[0];

    alu_flag_reg u_flag_reg (
        .clk   (Clk),
        .rst_n (Reset),
        .load  (FlagEn),
        .d     ({Zero, Even, carry_next}),
        .q     (flag_q)
    );

    assign FlagZero  = flag_q[2];
    assign FlagEven  = flag_q[1];
    assign FlagCarry = flag_q[0];

endmodule

// File: tb/tb_alu_unit.sv
// Directed table-driven bench for alu_unit plus hand-written flag register sequences.
module tb_alu_unit;

    logic       clk;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       flag_en;
    logic [7:0] out;
    logic       zero;
    logic       even;
    logic       flag_zero;
    logic       flag_even;
    logic       flag_carry;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_out;
        logic       exp_carry;
    } vec_t;

    vec_t vecs[22];

    alu_unit dut (
        .Clk       (clk),
        .Reset     (reset),
        .InputA    (a),
        .InputB    (b),
        .OP        (op),
        .FlagEn    (flag_en),
        .Out       (out),
        .Zero      (zero),
        .Even      (even),
        .FlagZero  (flag_zero),
        .FlagEven  (flag_even),
        .FlagCarry (flag_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, actual, expected);
        end
    endtask

    task automatic check_flags(input string name, input logic ez, input logic ev, input logic ec);
        check({name, "_fz"}, {7'd0, flag_zero},  {7'd0, ez});
        check({name, "_fe"}, {7'd0, flag_even},  {7'd0, ev});
        check({name, "_fc"}, {7'd0, flag_carry}, {7'd0, ec});
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 8'h01, 8'h01, 8'h02, 1'b0};
        vecs[1]  = '{4'b0001, 8'h01, 8'h00, 8'h00, 1'b1};
        vecs[2]  = '{4'b0000, 8'h80, 8'h00, 8'h00, 1'b1};
        vecs[3]  = '{4'b0010, 8'h01, 8'h01, 8'h01, 1'b0};
        vecs[4]  = '{4'b0011, 8'h01, 8'h00, 8'h01, 1'b0};
        vecs[5]  = '{4'b0100, 8'hF0, 8'h3C, 8'hCC, 1'b0};
        vecs[6]  = '{4'b1000, 8'h03, 8'h04, 8'h00, 1'b0};
        vecs[7]  = '{4'b1001, 8'h02, 8'h02, 8'h01, 1'b0};
        vecs[8]  = '{4'b1101, 8'h01, 8'h03, 8'h01, 1'b0};
        vecs[9]  = '{4'b1100, 8'h04, 8'h04, 8'h00, 1'b0};
        vecs[10] = '{4'b1011, 8'h01, 8'h01, 8'h02, 1'b0};
        vecs[11] = '{4'b1011, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[12] = '{4'b1010, 8'h01, 8'h00, 8'hFF, 1'b0};
        vecs[13] = '{4'b0101, 8'h02, 8'h05, 8'hFD, 1'b1};
        vecs[14] = '{4'b1010, 8'h80, 8'h00, 8'h80, 1'b0};
        vecs[15] = '{4'b1010, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[16] = '{4'b0110, 8'h5A, 8'hA5, 8'h5A, 1'b0};
        vecs[17] = '{4'b0111, 8'h5A, 8'hA5, 8'hA5, 1'b0};
        vecs[18] = '{4'b1000, 8'h04, 8'h03, 8'h01, 1'b0};
        vecs[19] = '{4'b1100, 8'h03, 8'h04, 8'h01, 1'b0};
        vecs[20] = '{4'b1110, 8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[21] = '{4'b1111, 8'hFF, 8'hFF, 8'h00, 1'b0};

        reset   = 1'b0;
        flag_en = 1'b0;
        a       = 8'h00;
        b       = 8'h00;
        op      = 4'b0110;

        // Reset hold: flags clear.
        @(posedge clk);
        #1;
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        $display("seq reset: flags %b%b%b", flag_zero, flag_even, flag_carry);

        // ADD 0xFF+0x01 with load enabled.
        @(negedge clk);
        reset   = 1'b1;
        a       = 8'hFF;
        b       = 8'h01;
        op      = 4'b1011;
        flag_en = 1'b1;
        #1;
        check("add_ovf_out", out, 8'h00);
        @(posedge clk);
        #1;
        check_flags("add_ovf", 1'b1, 1'b1, 1'b1);
        $display("seq add ff+01: out %02h flags %b%b%b", out, flag_zero, flag_even, flag_carry);

        // Load disabled: flags hold while Out tracks PASSA.
        @(negedge clk);
        flag_en = 1'b0;
        op      = 4'b0110;
        a       = 8'h01;
        #1;
        check("hold_out", out, 8'h01);
        @(posedge clk);
        #1;
        check_flags("hold", 1'b1, 1'b1, 1'b1);
        $display("seq hold: out %02h flags %b%b%b", out, flag_zero, flag_even, flag_carry);

        // Reset and load at the same edge: reset wins; Out unaffected.
        @(negedge clk);
        reset   = 1'b0;
        flag_en = 1'b1;
        a       = 8'h37;
        #1;
        check("rst_out", out, 8'h37);
        @(posedge clk);
        #1;
        check_flags("rst_prio", 1'b0, 1'b0, 1'b0);
        $display("seq reset priority: out %02h flags %b%b%b", out, flag_zero, flag_even, flag_carry);

        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            logic exp_zero;
            logic exp_even;
            logic [7:0] exp_o;
            @(negedge clk);
            op      = vecs[i].op;
            a       = vecs[i].a;
            b       = vecs[i].b;
            flag_en = 1'b1;
            exp_o    = vecs[i].exp_out;
            exp_zero = (exp_o == 8'h00);
            exp_even = ~exp_o[0];
            #1;
            check($sformatf("v%0d_out", i), out, exp_o);
            check($sformatf("v%0d_zero", i), {7'd0, zero}, {7'd0, exp_zero});
            check($sformatf("v%0d_even", i), {7'd0, even}, {7'd0, exp_even});
            @(posedge clk);
            #1;
            check_flags($sformatf("v%0d", i), exp_zero, exp_even, vecs[i].exp_carry);
            $display("vec %0d: op %b a %02h b %02h -> out %02h z %b e %b fc %b",
                     i, op, a, b, out, zero, even, flag_carry);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 8-bit arithmetic/logic unit for the basic single-cycle processor datapath.
- Combinational result path: Out is a function of InputA, InputB and OP within the same cycle.
- A small clocked status register captures condition flags (Zero, Even, Carry) for later branch/compare use.
- Sits between the register file read ports and the writeback mux.

Parameters:
- WIDTH, 8, data width of InputA, InputB and Out; all behaviour below is stated for 8.

Ports:
- Clk  input  1  system clock, rising-edge active.
- Reset  input  1  synchronous active-low reset, sampled on rising Clk.
- InputA  input  8  operand A.
- InputB  input  8  operand B.
- OP  input  4  opcode, encoded by the op_mne enum in the definitions package.
- FlagEn  input  1  when high, the status register captures the current flags at rising Clk.
- Out  output  8  combinational result.
- Zero  output  1  combinational; 1 when Out == 0.
- Even  output  1  combinational; equals ~Out[0].
- FlagZero  output  1  registered Zero.
- FlagEven  output  1  registered Even.
- FlagCarry  output  1  registered carry/borrow.

Behaviour:
- Out, Zero and Even are purely combinational, with zero latency.
  - They settle within the same delta/timestep as any input change.
  - They are independent of Clk and Reset.
- Opcodes (all arithmetic unsigned, modulo 256):
  - 0000 LSH: {A[6:0],0}; carry = A[7]; B ignored.
  - 0001 RSH: logical, {0,A[7:1]}; carry = A[0]; B ignored.
  - 0010 AND: A & B.
  - 0011 OR: A | B, bitwise.
  - 0100 XOR: A ^ B.
  - 0101 SUB: A - B; carry = 1 when A < B (borrow).
  - 0110 PASSA: A.
  - 0111 PASSB: B.
  - 1000 GEQ: 8'd1 if A >= B (unsigned), else 8'd0.
  - 1001 EQ: 8'd1 if A == B, else 8'd0.
  - 1010 NEG: two's complement of A (~A + 1); B ignored; NEG 0 = 0, NEG 0x80 = 0x80.
  - 1011 ADD: A + B truncated to 8 bits; carry = bit 8 of the 9-bit sum.
  - 1100 LT: 8'd1 if A < B (unsigned), else 8'd0.
  - 1101 NEQ: 8'd1 if A != B, else 8'd0.
  - 1110, 1111: reserved; Out = 0.
- Carry is 0 for every opcode not listed as producing carry.
- Compare results are zero-extended to 8 bits, with the result in bit 0.
- Status register, updated at rising Clk:
  - If Reset == 0: FlagZero, FlagEven, FlagCarry clear to 0. Reset has priority over FlagEn.
  - Else if FlagEn == 1: the three flags load Zero, Even, carry from the current cycle.
  - Else: the flags hold.
- Reset asserted mid-operation affects only the flag register; Out keeps tracking the inputs.
- No X propagation: every OP value drives a defined Out.

Decomposition:
- definitions package holds:
  - typedef enum logic[3:0] op_mne, with the 16 encodings above: LSH, RSH, AND, OR, XOR, SUB, PASSA, PASSB, GEQ, EQ, NEG, ADD, LT, NEQ, RSV0, RSV1.
  - WIDTH constant = 8.
- One sub-module: alu_flag_reg, the 3-bit synchronous active-low-reset register with load enable.
- The opcode decode/datapath stays in alu_unit as one always_comb case statement.

Test Plan:
- Shifts: A=1, B=1, OP=0000 -> Out=0x02. A=1, OP=0001 -> Out=0x00, carry=1. A=0x80, OP=0000 -> Out=0x00, Zero=1, carry=1.
- Logic: A=1, B=1, OP=0010 -> Out=0x01. A=1, B=0, OP=0011 -> Out=0x01. A=0xF0, B=0x3C, OP=0100 -> Out=0xCC.
- Compares: A=3, B=4, OP=1000 -> 0x00. A=2, B=2, OP=1001 -> 0x01. A=1, B=3, OP=1101 -> 0x01. A=4, B=4, OP=1100 -> 0x00.
- Arithmetic: A=1, B=1, OP=1011 -> 0x02. A=0xFF, B=0x01, OP=1011 -> 0x00, Zero=1, carry=1. A=1, OP=1010 -> 0xFF. A=2, B=5, OP=0101 -> 0xFD, carry=1.
- Flags register: hold Reset=0 one cycle -> all flags 0. Then ADD 0xFF+0x01 with FlagEn=1 -> FlagZero=1, FlagEven=1, FlagCarry=1 after the edge. Then FlagEn=0 and OP=PASSA, A=1 -> flags unchanged.
- Reset priority and reserved opcodes: Reset=0 with FlagEn=1 at the same edge -> flags 0. OP=1110 and OP=1111 with A=B=0xFF -> Out=0x00.
- Every check is sampled 1 ns after the input change.
